// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the serial pattern detector: WIDTH-bit words in
// over valid/ready, one bit per clock out, with a one-word holding buffer for gapless streaming.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] hb;
  logic [CW-1:0]    cnt;
  logic             hb_full;
  logic             acc;

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    if (MSB_FIRST)
      shift_once = {v[WIDTH-2:0], 1'b0};
    else
      shift_once = {1'b0, v[WIDTH-1:1]};
  endfunction

  // Outputs decode straight from state; rst masks them so a reset cycle looks idle.
  assign ser_valid = (cnt != '0) & ~rst;
  assign ser_out   = ser_valid ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : IDLE_BIT;
  assign word_done = (cnt == CW'(1)) & ~rst;
  assign busy      = ((cnt != '0) | hb_full) & ~rst;
  assign din_ready = ~hb_full & ~rst;
  assign acc       = din_valid & din_ready;

  // Stage boundary: shift register, bit counter and holding buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      hb_full <= 1'b0;
      sh      <= '0;
      hb      <= '0;
    end else if (cnt <= CW'(1)) begin
      // Idle or last bit: the next word (buffered first) starts on this edge.
      if (hb_full) begin
        sh      <= hb;
        cnt     <= CW'(WIDTH);
        hb_full <= acc;
        if (acc)
          hb <= din;
      end else if (acc) begin
        sh  <= din;
        cnt <= CW'(WIDTH);
      end else begin
        cnt <= '0;
      end
    end else begin
      sh  <= shift_once(sh);
      cnt <= cnt - CW'(1);
      if (acc) begin
        hb      <= din;
        hb_full <= 1'b1;
      end
    end
  end

endmodule
